// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared sizes, state/requester encodings and decode helpers for
//            the register-file port scheduler.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
    onehot       = '0;
    onehot[addr] = 1'b1;
  endfunction

  // R0 reads as zero; a same-cycle landing write overrides the stale bitline.
  function automatic logic [DATA_W-1:0] rd_bypass(
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] raw,
    input logic              wr_fire,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (rd_addr == '0)
      rd_bypass = '0;
    else if (wr_fire && (wr_addr == rd_addr))
      rd_bypass = wr_data;
    else
      rd_bypass = raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_port_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_sched_if
// Purpose  : Core/debug request bus into the register-file port scheduler.
// Revision : 1.0
// ============================================================================
interface regfile_port_sched_if;
  import regfile_pkg::*;

  logic              core_wr_valid;
  logic              core_wr_ready;
  logic [ADDR_W-1:0] core_wr_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic              dbg_wr_valid;
  logic              dbg_wr_ready;
  logic [ADDR_W-1:0] dbg_wr_addr;
  logic [DATA_W-1:0] dbg_wr_data;
  logic [ADDR_W-1:0] core_rd1_addr;
  logic [ADDR_W-1:0] core_rd2_addr;
  logic              core_rd2_en;
  logic [DATA_W-1:0] core_rd1_data;
  logic [DATA_W-1:0] core_rd2_data;
  logic              dbg_rd_valid;
  logic [ADDR_W-1:0] dbg_rd_addr;
  logic              dbg_rd_ready;
  logic              dbg_rd_dvalid;
  logic [DATA_W-1:0] dbg_rd_data;

  modport master (
    output core_wr_valid, core_wr_addr, core_wr_data,
    output dbg_wr_valid, dbg_wr_addr, dbg_wr_data,
    output core_rd1_addr, core_rd2_addr, core_rd2_en,
    output dbg_rd_valid, dbg_rd_addr,
    input  core_wr_ready, dbg_wr_ready,
    input  core_rd1_data, core_rd2_data,
    input  dbg_rd_ready, dbg_rd_dvalid, dbg_rd_data
  );

  modport slave (
    input  core_wr_valid, core_wr_addr, core_wr_data,
    input  dbg_wr_valid, dbg_wr_addr, dbg_wr_data,
    input  core_rd1_addr, core_rd2_addr, core_rd2_en,
    input  dbg_rd_valid, dbg_rd_addr,
    output core_wr_ready, dbg_wr_ready,
    output core_rd1_data, core_rd2_data,
    output dbg_rd_ready, dbg_rd_dvalid, dbg_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/rf_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : rf_onehot_dec
// Purpose  : Gated address to one-hot register enable decoder.
// Revision : 1.0
// ============================================================================
module rf_onehot_dec
  import regfile_pkg::*;
(
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  assign o_onehot = i_en ? onehot(i_addr) : '0;

endmodule
`default_nettype wire

// File: rtl/regfile_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_sched
// Purpose  : Post-reset clear sweep, round-robin write arbitration, bypassed
//            read decode and debug loan of read port 2 for the register file.
// Revision : 1.0
// ============================================================================
module regfile_port_sched
  import regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  regfile_port_sched_if.slave bus,
  output logic [NUM_REGS-1:0] rf_wr_en,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic [NUM_REGS-1:0] rf_rd1_en,
  output logic [NUM_REGS-1:0] rf_rd2_en,
  input  logic [DATA_W-1:0]   rf_rd1_data,
  input  logic [DATA_W-1:0]   rf_rd2_data,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] c_last_reg = ADDR_W'(NUM_REGS - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  req_t              r_rr_last, w_rr_nxt;
  logic              r_dbg_rd_dvalid;
  logic [DATA_W-1:0] r_dbg_rd_data;

  logic              w_run, w_sweep;
  logic              w_grant_core, w_grant_dbg, w_wr_fire;
  logic [ADDR_W-1:0] w_wr_addr, w_rd2_addr;
  logic [DATA_W-1:0] w_wr_data, w_dbg_rd_value;
  logic              w_rd2_active, w_dbg_rd_accept;

  assign w_run   = (r_state == ST_RUN);
  // Gated by rst so every enable is quiet while reset is held.
  assign w_sweep = (r_state == ST_CLEAR) && rst;
  assign busy    = (r_state == ST_CLEAR);

  assign w_grant_core = w_run && bus.core_wr_valid &&
                        (!bus.dbg_wr_valid || (r_rr_last == REQ_DBG));
  assign w_grant_dbg  = w_run && bus.dbg_wr_valid &&
                        (!bus.core_wr_valid || (r_rr_last == REQ_CORE));
  assign w_wr_addr    = w_grant_dbg ? bus.dbg_wr_addr : bus.core_wr_addr;
  assign w_wr_data    = w_grant_dbg ? bus.dbg_wr_data : bus.core_wr_data;
  assign w_wr_fire    = (w_grant_core || w_grant_dbg) && (w_wr_addr != '0);

  assign bus.core_wr_ready = w_grant_core;
  assign bus.dbg_wr_ready  = w_grant_dbg;
  assign rf_wr_data        = w_sweep ? CLEAR_VAL : w_wr_data;

  // Core always owns port 2 when it asks; debug only borrows idle cycles.
  assign w_dbg_rd_accept  = w_run && !bus.core_rd2_en && bus.dbg_rd_valid;
  assign w_rd2_active     = w_run && (bus.core_rd2_en || bus.dbg_rd_valid);
  assign w_rd2_addr       = bus.core_rd2_en ? bus.core_rd2_addr : bus.dbg_rd_addr;
  assign bus.dbg_rd_ready = w_dbg_rd_accept;

  assign bus.core_rd1_data = w_run ?
      rd_bypass(bus.core_rd1_addr, rf_rd1_data, w_wr_fire, w_wr_addr, w_wr_data) : '0;
  assign bus.core_rd2_data = (w_run && bus.core_rd2_en) ?
      rd_bypass(bus.core_rd2_addr, rf_rd2_data, w_wr_fire, w_wr_addr, w_wr_data) : '0;
  assign w_dbg_rd_value =
      rd_bypass(bus.dbg_rd_addr, rf_rd2_data, w_wr_fire, w_wr_addr, w_wr_data);

  assign bus.dbg_rd_dvalid = r_dbg_rd_dvalid;
  assign bus.dbg_rd_data   = r_dbg_rd_data;

  rf_onehot_dec u_dec_wr (
    .i_en     (w_sweep || w_wr_fire),
    .i_addr   (w_sweep ? r_cnt : w_wr_addr),
    .o_onehot (rf_wr_en)
  );

  rf_onehot_dec u_dec_rd1 (
    .i_en     (w_run),
    .i_addr   (bus.core_rd1_addr),
    .o_onehot (rf_rd1_en)
  );

  rf_onehot_dec u_dec_rd2 (
    .i_en     (w_rd2_active),
    .i_addr   (w_rd2_addr),
    .o_onehot (rf_rd2_en)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_last;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == c_last_reg)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_grant_core)
          w_rr_nxt = REQ_CORE;
        else if (w_grant_dbg)
          w_rr_nxt = REQ_DBG;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_CLEAR;
      r_cnt           <= '0;
      r_rr_last       <= REQ_DBG;
      r_dbg_rd_dvalid <= 1'b0;
      r_dbg_rd_data   <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_rr_last       <= w_rr_nxt;
      r_dbg_rd_dvalid <= w_dbg_rd_accept;
      if (w_dbg_rd_accept)
        r_dbg_rd_data <= w_dbg_rd_value;
    end
  end

endmodule
`default_nettype wire
